// File: rtl/cordic_result_collector_if.sv
// Handshake bundle between the CORDIC FSM, the result collector and the
// downstream consumer. The master modport is the collector's view.
interface cordic_result_collector_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          ready_CORDIC;
    logic [W-1:0]  data_output;
    logic          exception;
    logic          ACK_FSM_CORDIC;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_exc;
    logic          out_ready;
    logic [CW-1:0] fifo_count;
    logic          full;
    logic [15:0]   result_cnt;

    modport master (
        input  ready_CORDIC,
        input  data_output,
        input  exception,
        input  out_ready,
        output ACK_FSM_CORDIC,
        output out_valid,
        output out_data,
        output out_exc,
        output fifo_count,
        output full,
        output result_cnt
    );

    modport slave (
        output ready_CORDIC,
        output data_output,
        output exception,
        output out_ready,
        input  ACK_FSM_CORDIC,
        input  out_valid,
        input  out_data,
        input  out_exc,
        input  fifo_count,
        input  full,
        input  result_cnt
    );
endinterface

// File: rtl/cordic_result_collector.sv
// Captures CORDIC results with a one-cycle ACK handshake and buffers them in a
// show-ahead FIFO drained by a valid/ready consumer.
module cordic_result_collector #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    cordic_result_collector_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t        state;
    logic          ack;
    logic [15:0]   result_cnt;
    logic [W:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [W:0]    head;
    logic          full;
    logic          push;
    logic          pop;

    // full comes from the registered count, so a same-cycle pop never frees a slot early
    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0) && bus.out_ready;
    assign push = (state == IDLE) && bus.ready_CORDIC && !full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ack        <= 1'b0;
            result_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (push) begin
                        state      <= ACK;
                        ack        <= 1'b1;
                        result_cnt <= result_cnt + 16'd1;
                    end
                end
                ACK: begin
                    ack   <= 1'b0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    ack <= 1'b0;
                    // ready_CORDIC still high means the same result; wait it out
                    if (!bus.ready_CORDIC) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.exception, bus.data_output};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head               = mem[rd_ptr];
    assign bus.out_exc        = head[W];
    assign bus.out_data       = head[W-1:0];
    assign bus.out_valid      = (count != '0);
    assign bus.fifo_count     = count;
    assign bus.full           = full;
    assign bus.ACK_FSM_CORDIC = ack;
    assign bus.result_cnt     = result_cnt;
endmodule

// File: tb/tb_cordic_result_collector.sv
// Scoreboard bench for cordic_result_collector: directed captures push expected
// words; a negedge monitor pops and compares every consumer transfer.
module tb_cordic_result_collector;
    logic clk;
    logic reset;

    cordic_result_collector_if #(.W(32), .DEPTH(4)) bus ();

    cordic_result_collector #(.W(32), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors;
    int          miscompares;
    int          exp_cnt;
    logic [32:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every accepted head word must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got %0h expected none", {bus.out_exc, bus.out_data});
            end else begin
                check("pop_word", {31'd0, bus.out_exc, bus.out_data}, {31'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    // Issue one result from an IDLE collector with room; ACK expected next cycle.
    task automatic capture(input logic [31:0] d, input logic e);
        bit got;
        bus.ready_CORDIC = 1'b1;
        bus.data_output  = d;
        bus.exception    = e;
        exp_q.push_back({e, d});
        tick();
        check("ack_latency", bus.ACK_FSM_CORDIC, 1);
        got = bus.ACK_FSM_CORDIC;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            got = bus.ACK_FSM_CORDIC;
        end
        if (!got) check("ack_timeout", 0, 1);
        exp_cnt++;
        tick();
        check("ack_one_cycle", bus.ACK_FSM_CORDIC, 0);
        bus.ready_CORDIC = 1'b0;
        tick();
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (bus.fifo_count == 0) break;
            tick();
        end
        bus.out_ready = 1'b0;
        check("drain_empty", bus.fifo_count, 0);
        check("drain_valid", bus.out_valid, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vectors          = 0;
        miscompares      = 0;
        exp_cnt          = 0;
        reset            = 1'b0;
        bus.ready_CORDIC = 1'b0;
        bus.data_output  = '0;
        bus.exception    = 1'b0;
        bus.out_ready    = 1'b0;
        #3;
        check("rst_ack", bus.ACK_FSM_CORDIC, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_full", bus.full, 0);
        check("rst_rcnt", bus.result_cnt, 0);
        check("rst_data", {bus.out_exc, bus.out_data}, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick();

        // Single result into an empty FIFO
        capture(32'h3F800000, 1'b0);
        check("t1_valid", bus.out_valid, 1);
        check("t1_data", bus.out_data, 32'h3F800000);
        check("t1_count", bus.fifo_count, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t1_empty_count", bus.fifo_count, 0);
        check("t1_empty_valid", bus.out_valid, 0);

        // Fill to full, fifth result stalls until a slot is freed
        capture(32'h1, 1'b0);
        capture(32'h2, 1'b0);
        capture(32'h3, 1'b0);
        capture(32'h4, 1'b0);
        check("t2_count4", bus.fifo_count, 4);
        check("t2_full", bus.full, 1);
        bus.ready_CORDIC = 1'b1;
        bus.data_output  = 32'h5;
        exp_q.push_back({1'b0, 32'h5});
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_stall_ack", bus.ACK_FSM_CORDIC, 0);
            check("t2_stall_count", bus.fifo_count, 4);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t2_pop_ack", bus.ACK_FSM_CORDIC, 0);
        check("t2_pop_count", bus.fifo_count, 3);
        check("t2_pop_full", bus.full, 0);
        tick();
        check("t2_retry_ack", bus.ACK_FSM_CORDIC, 1);
        check("t2_retry_count", bus.fifo_count, 4);
        exp_cnt++;
        tick();
        check("t2_ack_low", bus.ACK_FSM_CORDIC, 0);
        bus.ready_CORDIC = 1'b0;
        tick();
        check("t2_rcnt", bus.result_cnt, exp_cnt);
        drain();

        // Slow deassert: ready held high five cycles after ACK
        bus.ready_CORDIC = 1'b1;
        bus.data_output  = 32'hA5A5A5A5;
        exp_q.push_back({1'b0, 32'hA5A5A5A5});
        tick();
        check("t3_ack", bus.ACK_FSM_CORDIC, 1);
        exp_cnt++;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_ack", bus.ACK_FSM_CORDIC, 0);
            check("t3_hold_count", bus.fifo_count, 1);
        end
        bus.ready_CORDIC = 1'b0;
        tick();
        tick();
        check("t3_rcnt", bus.result_cnt, exp_cnt);
        check("t3_count", bus.fifo_count, 1);

        // Simultaneous push and pop at count 2
        capture(32'h11111111, 1'b0);
        check("t4_count2", bus.fifo_count, 2);
        bus.ready_CORDIC = 1'b1;
        bus.data_output  = 32'h22222222;
        exp_q.push_back({1'b0, 32'h22222222});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t4_ack", bus.ACK_FSM_CORDIC, 1);
        check("t4_count", bus.fifo_count, 2);
        check("t4_head", bus.out_data, 32'h11111111);
        exp_cnt++;
        tick();
        bus.ready_CORDIC = 1'b0;
        tick();
        drain();

        // Exception tag follows its word through the FIFO
        capture(32'h7FC00000, 1'b1);
        check("t5_exc_head", bus.out_exc, 1);
        check("t5_exc_data", bus.out_data, 32'h7FC00000);
        capture(32'h40000000, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t5_norm_exc", bus.out_exc, 0);
        check("t5_norm_data", bus.out_data, 32'h40000000);
        check("t5_count", bus.fifo_count, 1);
        check("t5_rcnt", bus.result_cnt, exp_cnt);
        drain();

        // Asynchronous reset while in ACK with three entries
        capture(32'hAAAA0001, 1'b0);
        capture(32'hAAAA0002, 1'b0);
        bus.ready_CORDIC = 1'b1;
        bus.data_output  = 32'hAAAA0003;
        tick();
        check("t6_ack", bus.ACK_FSM_CORDIC, 1);
        check("t6_count", bus.fifo_count, 3);
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        bus.ready_CORDIC = 1'b0;
        check("t6_rst_ack", bus.ACK_FSM_CORDIC, 0);
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_count", bus.fifo_count, 0);
        check("t6_rst_full", bus.full, 0);
        check("t6_rst_rcnt", bus.result_cnt, 0);
        check("t6_rst_data", {bus.out_exc, bus.out_data}, 0);
        #3;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_ack", bus.ACK_FSM_CORDIC, 0);
            check("t6_no_count", bus.fifo_count, 0);
        end
        check("t6_rcnt", bus.result_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cordic_result_collector.md
Name: cordic_result_collector

Overview:
- Downstream stage of the CORDIC FSM/datapath.
- Waits for ready_CORDIC, captures the CORDIC result word, and returns the ACK_FSM_CORDIC handshake.
- Captured results go into a small FIFO, which is drained by a valid/ready consumer (FPU writeback/arbiter).
- Decouples CORDIC completion from consumer back-pressure, so the CORDIC FSM never waits in its done state longer than the FIFO-full condition requires.

Parameters:
- W, 32, result word width (single precision).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-low.
- ready_CORDIC  in  1  CORDIC done flag; held high until acknowledged.
- data_output  in  W  CORDIC result; valid while ready_CORDIC=1.
- exception  in  1  CORDIC exception flag; sampled with data and stored as a tag.
- ACK_FSM_CORDIC  out  1  one-cycle acknowledge to the CORDIC FSM.
- out_valid  out  1  FIFO non-empty.
- out_data  out  W  FIFO head word.
- out_exc  out  1  FIFO head exception tag.
- out_ready  in  1  consumer accepts the head when out_valid=1.
- fifo_count  out  CW  current occupancy.
- full  out  1  fifo_count==DEPTH.
- result_cnt  out  16  total results captured since reset; wraps at 0xFFFF->0.

Behaviour:
Reset (reset=0, asynchronous):
- State=IDLE; ACK_FSM_CORDIC=0; out_valid=0; fifo_count=0; full=0; result_cnt=0.
- Read/write pointers=0; out_data and out_exc=0.
- Reset mid-transfer discards all FIFO contents; no ACK is issued after release until a fresh ready_CORDIC is seen in IDLE.

FSM, states IDLE, ACK, WAIT_LOW:
- IDLE:
  - If ready_CORDIC=1 and full=0: write {exception,data_output} at the wr pointer on this edge, wr_ptr++, result_cnt++, go to ACK.
  - If ready_CORDIC=1 and full=1: stay in IDLE; no write, no ACK (CORDIC stalls in its done state).
- ACK:
  - ACK_FSM_CORDIC=1 for exactly this cycle (registered; high in the cycle after capture).
  - Next state is WAIT_LOW.
- WAIT_LOW:
  - ACK_FSM_CORDIC=0.
  - Stay while ready_CORDIC=1 (the CORDIC FSM needs one cycle to leave its done state); go to IDLE when ready_CORDIC=0.
  - Prevents double capture of the same result.
- Illegal state: go to IDLE, outputs low.

FIFO:
- out_valid=(fifo_count!=0).
- out_data/out_exc are driven combinationally from the rd pointer entry (show-ahead).
- Pop when out_valid & out_ready: rd_ptr++.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Push and pop in the same cycle: fifo_count is unchanged and both pointers advance.
- Capture decision uses full as registered at the start of the cycle; a same-cycle pop does not enable a push while full, and the push is retried next cycle.
- out_ready while empty is ignored; the count never underflows.
- fifo_count never exceeds DEPTH; overflow is structurally impossible.

Latency:
- ready_CORDIC rising edge sampled at edge N: data written at edge N; ACK high during cycle N+1.
- out_valid is high in cycle N+1 if the FIFO was empty.
- Minimum spacing between two captures is 3 cycles (IDLE->ACK->WAIT_LOW->IDLE).

Test Plan:
- Single result, empty FIFO: ready_CORDIC=1 with data_output=0x3F800000, exception=0, deasserted the cycle after ACK -> ACK high exactly one cycle (cycle N+1); out_valid=1, out_data=0x3F800000, fifo_count=1; with out_ready=1, empty next cycle.
- Fill to full: out_ready=0; 4 results 0x1,0x2,0x3,0x4; 5th ready_CORDIC held high -> no ACK, full=1, count=4. Pop one -> 5th captured next IDLE cycle, ACK follows. Drain order is 0x2,0x3,0x4,0x5.
- ready_CORDIC held high 5 cycles after ACK (slow deassert) -> exactly one capture, result_cnt increments by 1, FSM stays in WAIT_LOW until low.
- Simultaneous push/pop: count=2, capture coincides with out_ready=1 -> count stays 2, head advances, FIFO order preserved.
- Exception tag: capture 0x7FC00000 with exception=1 -> out_exc=1 at the head; the next normal result has out_exc=0.
- Async reset asserted in the ACK state with count=3 -> ACK, out_valid and count go to 0 immediately, independent of clk. After release with ready_CORDIC=0 -> no spurious ACK.
